// File: rtl/matrix_alu_pkg.sv
// Shared definitions for the Matrix Math Unit ALU path: opcodes and FSM states.
package matrix_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/row_lane_alu.sv
// One column of signed add/subtract with overflow detect and optional clamping.
module row_lane_alu #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  input  logic              sat,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MAX_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] sum;

  always_comb begin
    b_eff  = sub ? ~b : b;
    sum    = a + b_eff + {{(DATA_W-1){1'b0}}, sub};
    // Overflowed result always has the opposite sign of a; the true value has a's sign.
    ovf    = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    result = sum;
    if (ovf && sat) begin
      result = a[DATA_W-1] ? MAX_NEG : MAX_POS;
    end
  end

endmodule

// File: rtl/matrix_row_addsub.sv
// Multi-cycle signed row add/subtract: LANES columns per beat, result row
// published atomically with a one-cycle Done pulse.
module matrix_row_addsub
  import matrix_alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NCOLS  = 4,
  parameter int unsigned LANES  = 1
) (
  input  logic                    Clock,
  input  logic                    ClearAll,
  input  logic                    Enable,
  input  logic [2:0]              Operation,
  input  logic                    Saturate,
  input  logic [NCOLS*DATA_W-1:0] RowA,
  input  logic [NCOLS*DATA_W-1:0] RowB,
  output logic [NCOLS*DATA_W-1:0] NewRow,
  output logic                    Done,
  output logic                    Error,
  output logic                    Busy
);

  localparam int unsigned N     = NCOLS / LANES;
  localparam int unsigned ROW_W = NCOLS * DATA_W;
  localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1;

  generate
    if (LANES == 0 || (NCOLS % LANES) != 0) begin : g_bad_lanes
      $error("matrix_row_addsub: NCOLS must be a multiple of LANES");
    end
  endgenerate

  state_t state, state_nxt;

  logic [ROW_W-1:0]  a_q, b_q, shadow, shadow_nxt;
  logic              sub_q, sat_q, ovf_acc;
  logic [CW-1:0]     beat;
  logic              last_beat;
  logic [DATA_W-1:0] lane_a   [LANES];
  logic [DATA_W-1:0] lane_b   [LANES];
  logic [DATA_W-1:0] lane_res [LANES];
  logic [LANES-1:0]  lane_ovf;

  assign last_beat = (beat == CW'(N - 1));
  assign Busy      = (state == ST_RUN);

  always_comb begin
    shadow_nxt = shadow;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_a[l] = a_q[(32'(beat) * LANES + l) * DATA_W +: DATA_W];
      lane_b[l] = b_q[(32'(beat) * LANES + l) * DATA_W +: DATA_W];
      shadow_nxt[(32'(beat) * LANES + l) * DATA_W +: DATA_W] = lane_res[l];
    end
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      row_lane_alu #(.DATA_W(DATA_W)) u_lane (
        .a      (lane_a[g]),
        .b      (lane_b[g]),
        .sub    (sub_q),
        .sat    (sat_q),
        .result (lane_res[g]),
        .ovf    (lane_ovf[g])
      );
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (Enable && op_legal(Operation)) state_nxt = ST_RUN;
      ST_RUN:  if (last_beat) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (ClearAll) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge Clock) begin
    if (ClearAll) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sat_q   <= 1'b0;
      shadow  <= '0;
      beat    <= '0;
      ovf_acc <= 1'b0;
      NewRow  <= '0;
      Done    <= 1'b0;
      Error   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Enable) begin
            if (op_legal(Operation)) begin
              a_q     <= RowA;
              b_q     <= RowB;
              sub_q   <= (Operation == OP_SUB);
              sat_q   <= Saturate;
              beat    <= '0;
              ovf_acc <= 1'b0;
            end else begin
              Done  <= 1'b1;
              Error <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          shadow  <= shadow_nxt;
          ovf_acc <= ovf_acc | (|lane_ovf);
          beat    <= beat + CW'(1);
          // Final lanes go straight from shadow_nxt so the row is complete at Done.
          if (last_beat) begin
            NewRow <= shadow_nxt;
            Error  <= ovf_acc | (|lane_ovf);
            Done   <= 1'b1;
            beat   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_row_addsub.sv
// Directed bench for matrix_row_addsub: a LANES=1 and a LANES=4 instance.
module tb_matrix_row_addsub;

  logic         Clock;
  logic         ClearAll;
  logic         En1, En4;
  logic [2:0]   Operation;
  logic         Saturate;
  logic [127:0] RowA, RowB;
  logic [127:0] NewRow1, NewRow4;
  logic         Done1, Error1, Busy1;
  logic         Done4, Error4, Busy4;

  int errors = 0;
  int checks = 0;

  matrix_row_addsub #(.DATA_W(32), .NCOLS(4), .LANES(1)) dut1 (
    .Clock(Clock), .ClearAll(ClearAll), .Enable(En1), .Operation(Operation),
    .Saturate(Saturate), .RowA(RowA), .RowB(RowB), .NewRow(NewRow1),
    .Done(Done1), .Error(Error1), .Busy(Busy1)
  );

  matrix_row_addsub #(.DATA_W(32), .NCOLS(4), .LANES(4)) dut4 (
    .Clock(Clock), .ClearAll(ClearAll), .Enable(En4), .Operation(Operation),
    .Saturate(Saturate), .RowA(RowA), .RowB(RowB), .NewRow(NewRow4),
    .Done(Done4), .Error(Error4), .Busy(Busy4)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [127:0] row4(input logic [31:0] c1, c2, c3, c4);
    return {c4, c3, c2, c1};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Drive one accept edge on dut1 (which=0) or dut4 (which=1).
  task automatic start_op(input bit which, input logic [127:0] a, b,
                          input logic [2:0] op, input logic sat);
    RowA = a; RowB = b; Operation = op; Saturate = sat;
    if (which) En4 = 1'b1; else En1 = 1'b1;
    tick();
    En1 = 1'b0; En4 = 1'b0;
  endtask

  // Called just after the accept edge; returns edges until Done1 and Busy1 samples seen.
  task automatic run_to_done(output int done_edge, output int busy_cnt);
    done_edge = 0;
    busy_cnt  = 0;
    for (int k = 1; k <= 20 && done_edge == 0; k++) begin
      if (Busy1) busy_cnt++;
      tick();
      if (Done1) done_edge = k;
    end
  endtask

  task automatic test_reset();
    ClearAll = 1'b1;
    tick(); tick();
    ClearAll = 1'b0;
    checks++; if (NewRow1 !== '0) begin errors++; $display("FAIL reset_newrow got=%h exp=0", NewRow1); end
    checks++; if ({Done1, Error1, Busy1} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {Done1, Error1, Busy1}); end
    checks++; if ({NewRow4 != '0, Done4, Error4, Busy4} !== 4'b0000) begin errors++; $display("FAIL reset_dut4 got=%b exp=0000", {NewRow4 != '0, Done4, Error4, Busy4}); end
  endtask

  task automatic test_subtract();
    int de, bc;
    start_op(0, row4(10, 20, 30, 40), row4(1, 2, 3, 4), 3'b011, 1'b0);
    run_to_done(de, bc);
    checks++; if (de !== 4) begin errors++; $display("FAIL sub_latency got=%0d exp=4", de); end
    checks++; if (bc !== 4) begin errors++; $display("FAIL sub_busy_cycles got=%0d exp=4", bc); end
    checks++; if (NewRow1 !== row4(9, 18, 27, 36)) begin errors++; $display("FAIL sub_row got=%h exp=%h", NewRow1, row4(9, 18, 27, 36)); end
    checks++; if ({Error1, Busy1} !== 2'b00) begin errors++; $display("FAIL sub_err_busy got=%b exp=00", {Error1, Busy1}); end
    tick();
    checks++; if (Done1 !== 1'b0) begin errors++; $display("FAIL sub_done_pulse got=%b exp=0", Done1); end
  endtask

  task automatic test_illegal();
    start_op(0, row4(1, 1, 1, 1), row4(1, 1, 1, 1), 3'b111, 1'b0);
    checks++; if ({Done1, Error1, Busy1} !== 3'b110) begin errors++; $display("FAIL illegal_flags got=%b exp=110", {Done1, Error1, Busy1}); end
    checks++; if (NewRow1 !== row4(9, 18, 27, 36)) begin errors++; $display("FAIL illegal_row got=%h exp=%h", NewRow1, row4(9, 18, 27, 36)); end
    tick();
    checks++; if ({Done1, Error1, Busy1} !== 3'b010) begin errors++; $display("FAIL illegal_hold got=%b exp=010", {Done1, Error1, Busy1}); end
  endtask

  task automatic test_ignored_enable();
    int ndone, first;
    start_op(0, row4(1, 1, 1, 1), row4(2, 2, 2, 2), 3'b010, 1'b0);
    tick();
    RowA = row4(100, 100, 100, 100);
    En1 = 1'b1;
    tick();
    En1 = 1'b0;
    ndone = 0; first = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (Done1) begin ndone++; if (first == 0) first = k; end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignored_en_done_count got=%0d exp=1", ndone); end
    checks++; if (first !== 2) begin errors++; $display("FAIL ignored_en_done_edge got=%0d exp=2", first); end
    checks++; if (NewRow1 !== row4(3, 3, 3, 3)) begin errors++; $display("FAIL ignored_en_row got=%h exp=%h", NewRow1, row4(3, 3, 3, 3)); end
    checks++; if ({Error1, Busy1} !== 2'b00) begin errors++; $display("FAIL ignored_en_flags got=%b exp=00", {Error1, Busy1}); end
  endtask

  task automatic test_add_wrap_sat();
    int de, bc;
    start_op(0, row4(32'h7FFFFFFF, 0, 0, 0), row4(1, 0, 0, 0), 3'b010, 1'b0);
    run_to_done(de, bc);
    checks++; if (NewRow1 !== row4(32'h80000000, 0, 0, 0)) begin errors++; $display("FAIL add_wrap_row got=%h exp=%h", NewRow1, row4(32'h80000000, 0, 0, 0)); end
    checks++; if ({de == 4, Error1} !== 2'b11) begin errors++; $display("FAIL add_wrap_err got=%0d/%b exp=4/1", de, Error1); end
    tick();
    start_op(0, row4(32'h7FFFFFFF, 0, 0, 0), row4(1, 0, 0, 0), 3'b010, 1'b1);
    run_to_done(de, bc);
    checks++; if (NewRow1 !== row4(32'h7FFFFFFF, 0, 0, 0)) begin errors++; $display("FAIL add_sat_row got=%h exp=%h", NewRow1, row4(32'h7FFFFFFF, 0, 0, 0)); end
    checks++; if ({de == 4, Error1} !== 2'b11) begin errors++; $display("FAIL add_sat_err got=%0d/%b exp=4/1", de, Error1); end
    tick();
  endtask

  task automatic test_sub_sat();
    int de, bc;
    start_op(0, row4(32'h80000000, -32'sd5, 0, 0), row4(1, 3, 0, 0), 3'b011, 1'b1);
    run_to_done(de, bc);
    checks++; if (NewRow1 !== row4(32'h80000000, 32'hFFFFFFF8, 0, 0)) begin errors++; $display("FAIL sub_sat_row got=%h exp=%h", NewRow1, row4(32'h80000000, 32'hFFFFFFF8, 0, 0)); end
    checks++; if (Error1 !== 1'b1) begin errors++; $display("FAIL sub_sat_err got=%b exp=1", Error1); end
    tick();
    // Clean op afterwards so Error must drop back to 0.
    start_op(0, row4(5, 6, 7, 8), row4(1, 1, 1, 1), 3'b010, 1'b0);
    run_to_done(de, bc);
    checks++; if ({NewRow1 == row4(6, 7, 8, 9), Error1} !== 2'b10) begin errors++; $display("FAIL err_clear got=%h/%b exp=%h/0", NewRow1, Error1, row4(6, 7, 8, 9)); end
    tick();
  endtask

  task automatic test_reset_midop();
    int ndone;
    start_op(0, row4(5, 6, 7, 8), row4(1, 1, 1, 1), 3'b010, 1'b0);
    tick();
    ClearAll = 1'b1;
    tick();
    ClearAll = 1'b0;
    checks++; if (NewRow1 !== '0) begin errors++; $display("FAIL midop_row got=%h exp=0", NewRow1); end
    checks++; if ({Done1, Error1, Busy1} !== 3'b000) begin errors++; $display("FAIL midop_flags got=%b exp=000", {Done1, Error1, Busy1}); end
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (Done1) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL midop_no_done got=%0d exp=0", ndone); end
    RowA = row4(1, 1, 1, 1); RowB = row4(1, 1, 1, 1); Operation = 3'b010;
    ClearAll = 1'b1; En1 = 1'b1;
    tick();
    ClearAll = 1'b0; En1 = 1'b0;
    checks++; if (Busy1 !== 1'b0) begin errors++; $display("FAIL clear_priority_busy got=%b exp=0", Busy1); end
    tick();
    checks++; if ({Done1, Busy1} !== 2'b00) begin errors++; $display("FAIL clear_priority_idle got=%b exp=00", {Done1, Busy1}); end
  endtask

  task automatic test_back_to_back();
    start_op(1, row4(1, 2, 3, 4), row4(10, 20, 30, 40), 3'b010, 1'b0);
    checks++; if ({Busy4, Done4} !== 2'b10) begin errors++; $display("FAIL b2b_busy got=%b exp=10", {Busy4, Done4}); end
    tick();
    checks++; if ({Done4, Busy4, Error4} !== 3'b100) begin errors++; $display("FAIL b2b_done1 got=%b exp=100", {Done4, Busy4, Error4}); end
    checks++; if (NewRow4 !== row4(11, 22, 33, 44)) begin errors++; $display("FAIL b2b_row1 got=%h exp=%h", NewRow4, row4(11, 22, 33, 44)); end
    start_op(1, row4(5, 5, 5, 5), row4(1, 2, 3, 4), 3'b011, 1'b0);
    checks++; if ({Busy4, Done4, NewRow4 == row4(11, 22, 33, 44)} !== 3'b101) begin errors++; $display("FAIL b2b_accept got=%b exp=101", {Busy4, Done4, NewRow4 == row4(11, 22, 33, 44)}); end
    tick();
    checks++; if (Done4 !== 1'b1) begin errors++; $display("FAIL b2b_done2 got=%b exp=1", Done4); end
    checks++; if (NewRow4 !== row4(4, 3, 2, 1)) begin errors++; $display("FAIL b2b_row2 got=%h exp=%h", NewRow4, row4(4, 3, 2, 1)); end
  endtask

  initial begin
    ClearAll = 1'b1; En1 = 1'b0; En4 = 1'b0; Operation = 3'b000; Saturate = 1'b0;
    RowA = '0; RowB = '0;
    test_reset();
    test_subtract();
    test_illegal();
    test_ignored_enable();
    test_add_wrap_sat();
    test_sub_sat();
    test_reset_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_row_addsub.md
# matrix_row_addsub

Parametrised, multi-cycle signed row add/subtract unit for the Matrix Math Unit ALU path. It accepts one row from Matrix A and one row from Matrix B from ALU_Control and processes `LANES` columns per cycle over `NCOLS/LANES` beats. It returns the full result row atomically with a one-cycle `Done` pulse. It supports wrap or saturating arithmetic and reports signed overflow and illegal operations on `Error`.

## Interface
Parameters:
- `DATA_W`, 32, column element width (two's complement).
- `NCOLS`, 4, columns per row.
- `LANES`, 1, columns processed per beat. `NCOLS % LANES` must be 0, otherwise elaboration fails.

Ports:
- `Clock`  in  1  sole clock; all state changes on the rising edge.
- `ClearAll`  in  1  reset, synchronous and active-high; priority over everything.
- `Enable`  in  1  start request; sampled only in IDLE.
- `Operation`  in  3  3'b010 = A+B, 3'b011 = A−B; all other codes are illegal.
- `Saturate`  in  1  1 = clamp on overflow, 0 = wrap; captured at accept.
- `RowA`  in  NCOLS*DATA_W  Matrix A row; column 1 is in bits [DATA_W-1:0].
- `RowB`  in  NCOLS*DATA_W  Matrix B row; same packing as `RowA`.
- `NewRow`  out  NCOLS*DATA_W  result row; valid while `Done`=1, held until the next `Done`.
- `Done`  out  1  one-cycle completion pulse.
- `Error`  out  1  overflow in any column, or illegal op, for the last completed op; held until the next `Done` or `ClearAll`.
- `Busy`  out  1  high from accept until completion.

## Operation
- FSM states: IDLE, RUN.
- IDLE with `Enable`=1 and a legal op:
  - capture `RowA`, `RowB`, `Operation`, `Saturate`;
  - clear the beat counter and overflow accumulator;
  - go to RUN.
- IDLE with `Enable`=1 and an illegal op:
  - stay in IDLE;
  - next cycle `Done`=1 and `Error`=1;
  - `NewRow` unchanged.
- RUN, beat k (0..NCOLS/LANES−1):
  - compute columns k*LANES .. k*LANES+LANES−1 into a shadow register;
  - OR the per-column overflow into the accumulator.
- RUN, last beat:
  - copy the shadow register (including the final lanes) to `NewRow`;
  - `Error` takes the final accumulator value;
  - `Done` is set and `Busy` clears;
  - return to IDLE.
- Arithmetic:
  - full DATA_W signed add/subtract;
  - overflow = operands of the relevant signs produce a result of the opposite sign;
  - wrap mode keeps the low DATA_W bits;
  - saturate mode clamps to 2^(DATA_W−1)−1 or −2^(DATA_W−1);
  - overflow sets `Error` in both modes.
- `Enable` while `Busy`=1 is ignored; there is no queueing.
- `ClearAll` in any state:
  - go to IDLE;
  - `NewRow`=0, `Done`=0, `Error`=0, `Busy`=0;
  - shadow register and counter cleared;
  - an aborted op never produces `Done`.
- Reset values: every output is 0.

## Timing
- Define the accept edge as T. Beats occur at edges T+1 .. T+N, with N = NCOLS/LANES.
- `Busy` is high in the cycles after edges T .. T+N−1.
- `Done`, `NewRow` and `Error` update at edge T+N; `Done` falls at T+N+1.
- Latency from accept to `Done` is N cycles. For an illegal op, `Done` rises at T+1.
- Back-to-back operation: `Enable` sampled at edge T+N+1 (the cycle `Done` is high) is accepted. Peak throughput is one row per N+1 cycles.
- `ClearAll` and `Enable` at the same edge: `ClearAll` wins and the op is not accepted.

## Structure
- Package `matrix_alu_pkg` holds:
  - opcode constants `OP_ADD`=3'b010 and `OP_SUB`=3'b011, shared with ALU_Control and future ALU units;
  - the FSM state enum.
- Sub-module `row_lane_alu` (combinational, one instance per lane):
  - inputs: a, b, sub, sat;
  - outputs: result, ovf.
- Top level contains the FSM, capture registers, beat counter, shadow register, overflow accumulator and lane mux.

## Test plan
All scenarios use DATA_W=32, NCOLS=4, LANES=1 unless stated.
- **Subtract:** A=[10,20,30,40], B=[1,2,3,4], op 011 → `Done` at T+4, `NewRow`=[9,18,27,36], `Error`=0, `Busy` high for 4 cycles.
- **Add, wrap:** A1=0x7FFFFFFF, B1=1, other columns 0, `Saturate`=0, op 010 → col1=0x80000000, `Error`=1. Then rerun with `Saturate`=1 → col1=0x7FFFFFFF, `Error`=1.
- **Subtract, saturate:** A=[0x80000000,−5,0,0], B=[1,3,0,0], `Saturate`=1 → [0x80000000,−8,0,0], `Error`=1.
- **Illegal op, ignored Enable:** op 111 with prior `NewRow`=[9,18,27,36] → `Done`/`Error` at T+1, `NewRow` unchanged. Also, a second `Enable` pulsed at T+2 of a legal op is ignored, giving exactly one `Done`.
- **Reset mid-op and reset priority:** `ClearAll` at T+2 → all outputs 0 next cycle and no `Done`. `ClearAll` coincident with `Enable` → stays IDLE.
- **LANES=4, back-to-back:** `Done` at T+1. A second `Enable` on the `Done` cycle is accepted, and its `Done` follows 2 edges later.
